// File: rtl/text_term_pkg.sv
// Shared constants, character codes and FSM encoding for the text console writer.
// No ports; imported by text_console_writer and vram_bus_master.
package text_term_pkg;

  localparam int unsigned TERM_COLS  = 40;
  localparam int unsigned TERM_ROWS  = 30;
  localparam int unsigned TERM_WORDS = TERM_COLS * TERM_ROWS / 4;

  localparam logic [31:0] VRAM_BASE = 32'h2000_0000;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TILDE = 8'h7E;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUT,
    ST_SCR_RD,
    ST_SCR_WR,
    ST_SCR_FILL,
    ST_CLEAR
  } term_state_e;

  // Byte address of a 32-bit VRAM word given its word index.
  function automatic logic [31:0] vram_word_addr(input logic [31:0] base, input logic [8:0] word);
    return base + {21'd0, word, 2'b00};
  endfunction

endpackage

// File: rtl/vram_bus_master.sv
// One-request-at-a-time VRAM bus master. A request is latched when start is high and the bus is
// idle; mem_valid and payload are held until mem_ready, then mem_valid drops for at least one
// cycle. Ports: clk, reset_n (sync, active-low); start/addr/wdata/wstrb request in;
// done_c/rdata_c completion out (combinational, valid in the mem_ready cycle);
// mem_valid/mem_addr/mem_wdata/mem_wstrb/mem_rdata/mem_ready bus side.
module vram_bus_master
  import text_term_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        done_c,
  output logic [31:0] rdata_c,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  // Request register: start is ignored while a request is outstanding and in the completion cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else if (mem_valid) begin
      if (mem_ready) mem_valid <= 1'b0;
    end else if (start) begin
      mem_valid <= 1'b1;
      mem_addr  <= addr;
      mem_wdata <= wdata;
      mem_wstrb <= wstrb;
    end
  end

  assign done_c  = mem_valid & mem_ready;
  assign rdata_c = mem_rdata;

endmodule

// File: rtl/text_console_writer.sv
// Hardware TTY front end for the character VRAM: accepts bytes, tracks the cursor, handles
// LF/CR/BS/FF, scrolls and clears via the VRAM bus master.
// Ports: clk, reset_n (sync, active-low); ch_valid/ch_data/ch_ready byte stream; busy;
// cursor_col/cursor_row; mem_* VRAM master bus.
module text_console_writer
  import text_term_pkg::*;
#(
  parameter int unsigned COLS      = TERM_COLS,
  parameter int unsigned ROWS      = TERM_ROWS,
  parameter logic [31:0] BASE_ADDR = VRAM_BASE,
  parameter logic [7:0]  FILL_CHAR = CH_SPACE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ch_valid,
  input  logic [7:0]  ch_data,
  output logic        ch_ready,
  output logic        busy,
  output logic [5:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int unsigned ROW_WORDS = COLS / 4;
  localparam int unsigned SCR_WORDS = (ROWS - 1) * ROW_WORDS;
  localparam int unsigned ALL_WORDS = ROWS * ROW_WORDS;
  localparam logic [31:0] FILL_WORD = {4{FILL_CHAR}};

  term_state_e state, state_next;
  logic [5:0]  col_next;
  logic [4:0]  row_next;
  logic [10:0] cur_idx;
  logic [10:0] put_idx, put_idx_next;
  logic [7:0]  put_byte, put_byte_next;
  logic        scroll_pend, scroll_next;
  logic [8:0]  word_cnt, word_next;
  logic [31:0] rd_word, rd_word_next;
  logic        req_start;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        done_c;
  logic [31:0] rdata_c;

  assign cur_idx = 11'(cursor_row) * 11'(COLS) + 11'(cursor_col);

  vram_bus_master u_bus (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (req_start),
    .addr      (req_addr),
    .wdata     (req_wdata),
    .wstrb     (req_wstrb),
    .done_c    (done_c),
    .rdata_c   (rdata_c),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cursor_col  <= '0;
      cursor_row  <= '0;
      put_idx     <= '0;
      put_byte    <= '0;
      scroll_pend <= 1'b0;
      word_cnt    <= '0;
      rd_word     <= '0;
      ch_ready    <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      cursor_col  <= col_next;
      cursor_row  <= row_next;
      put_idx     <= put_idx_next;
      put_byte    <= put_byte_next;
      scroll_pend <= scroll_next;
      word_cnt    <= word_next;
      rd_word     <= rd_word_next;
      ch_ready    <= (state_next == ST_IDLE);
      busy        <= (state_next != ST_IDLE);
    end
  end

  // Next-state, cursor update and bus request generation.
  always_comb begin
    state_next    = state;
    col_next      = cursor_col;
    row_next      = cursor_row;
    put_idx_next  = put_idx;
    put_byte_next = put_byte;
    scroll_next   = scroll_pend;
    word_next     = word_cnt;
    rd_word_next  = rd_word;
    req_start     = 1'b0;
    req_addr      = '0;
    req_wdata     = '0;
    req_wstrb     = '0;

    case (state)
      ST_IDLE: begin
        if (ch_valid && ch_ready) begin
          word_next   = '0;
          scroll_next = 1'b0;
          if ((ch_data >= CH_SPACE) && (ch_data <= CH_TILDE)) begin
            // Write goes to the pre-advance position; the cursor moves now.
            put_idx_next  = cur_idx;
            put_byte_next = ch_data;
            state_next    = ST_PUT;
            if (cursor_col == 6'(COLS - 1)) begin
              col_next = '0;
              if (cursor_row == 5'(ROWS - 1)) scroll_next = 1'b1;
              else                             row_next    = cursor_row + 5'd1;
            end else begin
              col_next = cursor_col + 6'd1;
            end
          end else begin
            case (ch_data)
              CH_LF: begin
                col_next = '0;
                if (cursor_row == 5'(ROWS - 1)) state_next = ST_SCR_RD;
                else                             row_next   = cursor_row + 5'd1;
              end
              CH_CR: col_next = '0;
              CH_BS: begin
                if (cursor_col != '0) begin
                  col_next      = cursor_col - 6'd1;
                  put_idx_next  = cur_idx - 11'd1;
                  put_byte_next = FILL_CHAR;
                  state_next    = ST_PUT;
                end
              end
              CH_FF:   state_next = ST_CLEAR;
              default: ;
            endcase
          end
        end
      end

      ST_PUT: begin
        req_start = 1'b1;
        req_addr  = vram_word_addr(BASE_ADDR, put_idx[10:2]);
        req_wdata = {4{put_byte}};
        req_wstrb = 4'b0001 << put_idx[1:0];
        if (done_c) state_next = scroll_pend ? ST_SCR_RD : ST_IDLE;
      end

      // Scroll: copy word w+ROW_WORDS down to w, one read then one write per word.
      ST_SCR_RD: begin
        req_start = 1'b1;
        req_addr  = vram_word_addr(BASE_ADDR, word_cnt + 9'(ROW_WORDS));
        if (done_c) begin
          rd_word_next = rdata_c;
          state_next   = ST_SCR_WR;
        end
      end

      ST_SCR_WR: begin
        req_start = 1'b1;
        req_addr  = vram_word_addr(BASE_ADDR, word_cnt);
        req_wdata = rd_word;
        req_wstrb = 4'hF;
        if (done_c) begin
          word_next  = word_cnt + 9'd1;
          state_next = (word_cnt == 9'(SCR_WORDS - 1)) ? ST_SCR_FILL : ST_SCR_RD;
        end
      end

      // Counter continues from the first word of the last row.
      ST_SCR_FILL: begin
        req_start = 1'b1;
        req_addr  = vram_word_addr(BASE_ADDR, word_cnt);
        req_wdata = FILL_WORD;
        req_wstrb = 4'hF;
        if (done_c) begin
          if (word_cnt == 9'(ALL_WORDS - 1)) state_next = ST_IDLE;
          else                                word_next  = word_cnt + 9'd1;
        end
      end

      ST_CLEAR: begin
        req_start = 1'b1;
        req_addr  = vram_word_addr(BASE_ADDR, word_cnt);
        req_wdata = FILL_WORD;
        req_wstrb = 4'hF;
        if (done_c) begin
          if (word_cnt == 9'(ALL_WORDS - 1)) begin
            state_next = ST_IDLE;
            col_next   = '0;
            row_next   = '0;
          end else begin
            word_next = word_cnt + 9'd1;
          end
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Self-checking bench for text_console_writer: BRAM slave model with 2-cycle ready, a
// character-grid reference model, a vector table, hand-written corner sequences and random bytes.
module tb_text_console_writer;
  import text_term_pkg::*;

  localparam int unsigned COLS  = TERM_COLS;
  localparam int unsigned ROWS  = TERM_ROWS;
  localparam int unsigned WORDS = TERM_WORDS;
  localparam int LIMIT = 20000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ch_valid = 1'b0;
  logic [7:0]  ch_data = 8'h00;
  logic        ch_ready, busy;
  logic [5:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        mem_valid;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'hDEAD_BEEF;
  logic        mem_ready = 1'b0;

  always #5 clk = ~clk;

  text_console_writer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ch_valid   (ch_valid),
    .ch_data    (ch_data),
    .ch_ready   (ch_ready),
    .busy       (busy),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- BRAM slave ----------------
  logic [31:0] vram [WORDS];
  bit          vram_init = 1'b0;
  int unsigned slave_wait = 0;
  int          wr_cnt = 0, rd_cnt = 0, slave_err = 0;
  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];
  logic [3:0]  log_strb [$];

  always @(posedge clk) begin : slave
    int unsigned widx;
    if (!vram_init) begin
      for (int i = 0; i < int'(WORDS); i++) vram[i] = 32'h2020_2020;
      vram_init = 1'b1;
    end
    if (!reset_n) begin
      mem_ready  <= 1'b0;
      mem_rdata  <= 32'hDEAD_BEEF;
      slave_wait = 0;
    end else if (mem_ready) begin
      mem_ready  <= 1'b0;
      mem_rdata  <= 32'hDEAD_BEEF;
      slave_wait = 0;
    end else if (mem_valid) begin
      slave_wait++;
      if (slave_wait == 2) begin
        mem_ready <= 1'b1;
        widx = (mem_addr - VRAM_BASE) >> 2;
        if (mem_addr[1:0] != 2'b00 || mem_addr < VRAM_BASE || widx >= WORDS) begin
          slave_err++;
        end else if (mem_wstrb == 4'h0) begin
          mem_rdata <= vram[widx];
          rd_cnt++;
        end else begin
          for (int k = 0; k < 4; k++)
            if (mem_wstrb[k]) vram[widx][8*k +: 8] = mem_wdata[8*k +: 8];
          wr_cnt++;
          log_addr.push_back(mem_addr);
          log_data.push_back(mem_wdata);
          log_strb.push_back(mem_wstrb);
        end
      end
    end
  end

  // ---------------- bus protocol monitor ----------------
  logic        pv = 1'b0, pr = 1'b0;
  logic [31:0] pa = '0, pd = '0;
  logic [3:0]  ps = '0;
  int          prot_err = 0;

  always @(negedge clk) begin
    if (reset_n && pv && !pr &&
        (!mem_valid || mem_addr != pa || mem_wdata != pd || mem_wstrb != ps)) prot_err++;
    if (reset_n && pr && mem_valid) prot_err++;
    if (busy === ch_ready) prot_err++;
    pv = mem_valid; pr = mem_ready; pa = mem_addr; pd = mem_wdata; ps = mem_wstrb;
  end

  // ---------------- reference model ----------------
  byte unsigned scr [ROWS*COLS];
  int mc = 0, mr = 0;
  int exp_wr = 0, exp_rd = 0;

  task automatic model_scroll();
    for (int i = 0; i < int'((ROWS-1)*COLS); i++) scr[i] = scr[i+COLS];
    for (int i = int'((ROWS-1)*COLS); i < int'(ROWS*COLS); i++) scr[i] = 8'h20;
    exp_rd += int'(WORDS - COLS/4);
    exp_wr += int'(WORDS);
  endtask

  task automatic model_newline();
    mc = 0;
    if (mr == int'(ROWS) - 1) model_scroll();
    else mr++;
  endtask

  task automatic model_apply(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      scr[mr*COLS + mc] = b;
      exp_wr++;
      mc++;
      if (mc == int'(COLS)) model_newline();
    end else if (b == 8'h0A) begin
      model_newline();
    end else if (b == 8'h0D) begin
      mc = 0;
    end else if (b == 8'h08) begin
      if (mc > 0) begin
        mc--;
        scr[mr*COLS + mc] = 8'h20;
        exp_wr++;
      end
    end else if (b == 8'h0C) begin
      for (int i = 0; i < int'(ROWS*COLS); i++) scr[i] = 8'h20;
      exp_wr += int'(WORDS);
      mc = 0;
      mr = 0;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output int busy_cycles);
    int n;
    n = 0;
    while (!ch_ready && n < LIMIT) begin @(negedge clk); n++; end
    if (n >= LIMIT) check("ready_timeout_pre", 32'(n), 32'(0));
    ch_valid = 1'b1;
    ch_data  = b;
    @(negedge clk);
    ch_valid = 1'b0;
    ch_data  = 8'($urandom);
    busy_cycles = 0;
    while (!ch_ready && busy_cycles < LIMIT) begin @(negedge clk); busy_cycles++; end
    if (busy_cycles >= LIMIT) check("ready_timeout", 32'(busy_cycles), 32'(0));
  endtask

  task automatic send_and_model(input logic [7:0] b);
    int bc;
    send_byte(b, bc);
    model_apply(b);
    check("cursor_col", 32'(cursor_col), 32'(mc));
    check("cursor_row", 32'(cursor_row), 32'(mr));
    check("write_count", 32'(wr_cnt), 32'(exp_wr));
    check("read_count", 32'(rd_cnt), 32'(exp_rd));
  endtask

  task automatic compare_vram(input string nm);
    int bad;
    bad = 0;
    for (int i = 0; i < int'(WORDS); i++)
      for (int k = 0; k < 4; k++)
        if (vram[i][8*k +: 8] != scr[4*i + k]) bad++;
    check(nm, 32'(bad), 32'(0));
  endtask

  task automatic check_last_write(input string nm, input logic [31:0] a, input logic [3:0] s,
                                  input logic [31:0] d);
    if (log_addr.size() == 0) begin
      check({nm, "_present"}, 32'(0), 32'(1));
    end else begin
      check({nm, "_addr"}, log_addr[$], a);
      check({nm, "_strb"}, 32'(log_strb[$]), 32'(s));
      check({nm, "_data"}, log_data[$], d);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    mc = 0;
    mr = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  b;
    int          col;
    int          row;
    int          nwr;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int bc, w0, base, bad, r;
    logic [7:0] b;
    logic [2:0] lat_exp [5];

    tbl[0]  = '{8'h07, 1, 0, 0, 32'h0,         4'h0, 32'h0};
    tbl[1]  = '{8'h78, 2, 0, 1, 32'h2000_0000, 4'h2, 32'h7878_7878};
    tbl[2]  = '{8'h0A, 0, 1, 0, 32'h0,         4'h0, 32'h0};
    tbl[3]  = '{8'h71, 1, 1, 1, 32'h2000_0028, 4'h1, 32'h7171_7171};
    tbl[4]  = '{8'h08, 0, 1, 1, 32'h2000_0028, 4'h1, 32'h2020_2020};
    tbl[5]  = '{8'h08, 0, 1, 0, 32'h0,         4'h0, 32'h0};
    tbl[6]  = '{8'h0D, 0, 1, 0, 32'h0,         4'h0, 32'h0};
    tbl[7]  = '{8'hFF, 0, 1, 0, 32'h0,         4'h0, 32'h0};
    tbl[8]  = '{8'h7E, 1, 1, 1, 32'h2000_0028, 4'h1, 32'h7E7E_7E7E};
    tbl[9]  = '{8'h7F, 1, 1, 0, 32'h0,         4'h0, 32'h0};
    tbl[10] = '{8'h20, 2, 1, 1, 32'h2000_0028, 4'h2, 32'h2020_2020};
    tbl[11] = '{8'h0D, 0, 1, 0, 32'h0,         4'h0, 32'h0};

    // {mem_valid, mem_ready, ch_ready} at negedges after accept edge +0..+4
    lat_exp[0] = 3'b000; lat_exp[1] = 3'b100; lat_exp[2] = 3'b100;
    lat_exp[3] = 3'b110; lat_exp[4] = 3'b001;

    for (int i = 0; i < int'(ROWS*COLS); i++) scr[i] = 8'h20;

    // Reset state
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mem_valid", 32'(mem_valid), 32'(0));
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'(0));
    check("rst_ch_ready", 32'(ch_ready), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_col", 32'(cursor_col), 32'(0));
    check("rst_row", 32'(cursor_row), 32'(0));
    reset_n = 1'b1;
    @(negedge clk);

    // 'A' at reset: handshake latency and the single write
    ch_valid = 1'b1;
    ch_data  = 8'h41;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      ch_valid = 1'b0;
      ch_data  = 8'h00;
      check($sformatf("latency_%0d", k), 32'({mem_valid, mem_ready, ch_ready}), 32'(lat_exp[k]));
    end
    model_apply(8'h41);
    check("A_writes", 32'(wr_cnt), 32'(1));
    check_last_write("A", 32'h2000_0000, 4'h1, 32'h4141_4141);
    check("A_col", 32'(cursor_col), 32'(1));
    check("A_row", 32'(cursor_row), 32'(0));

    // Table vectors
    foreach (tbl[i]) begin
      w0 = wr_cnt;
      send_and_model(tbl[i].b);
      check($sformatf("tbl%0d_col", i), 32'(cursor_col), 32'(tbl[i].col));
      check($sformatf("tbl%0d_row", i), 32'(cursor_row), 32'(tbl[i].row));
      check($sformatf("tbl%0d_nwr", i), 32'(wr_cnt - w0), 32'(tbl[i].nwr));
      if (tbl[i].nwr > 0)
        check_last_write($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].strb, tbl[i].data);
    end
    compare_vram("vram_after_table");

    // 41 x 'B' from (0,0): row wrap boundary
    do_reset();
    base = log_addr.size();
    for (int i = 0; i < 41; i++) send_and_model(8'h42);
    check("B39_addr", log_addr[base+39], 32'h2000_0024);
    check("B39_strb", 32'(log_strb[base+39]), 32'(4'b1000));
    check("B40_addr", log_addr[base+40], 32'h2000_0028);
    check("B40_strb", 32'(log_strb[base+40]), 32'(4'b0001));
    check("B_col", 32'(cursor_col), 32'(1));
    check("B_row", 32'(cursor_row), 32'(1));

    // Fill screen with row-id chars, LF on the last row scrolls
    do_reset();
    for (int rr = 0; rr < int'(ROWS); rr++)
      for (int c = 0; c < ((rr == int'(ROWS) - 1) ? int'(COLS) - 1 : int'(COLS)); c++)
        send_and_model(8'(8'h30 + rr));
    compare_vram("vram_filled");
    w0 = rd_cnt;
    base = wr_cnt;
    send_and_model(8'h0A);
    check("scroll_reads", 32'(rd_cnt - w0), 32'(290));
    check("scroll_writes", 32'(wr_cnt - base), 32'(300));
    check("scroll_col", 32'(cursor_col), 32'(0));
    check("scroll_row", 32'(cursor_row), 32'(29));
    check("scroll_word0", vram[0], 32'h3131_3131);
    check("scroll_lastword", vram[WORDS-1], 32'h2020_2020);
    compare_vram("vram_scrolled");

    // Form feed after text
    send_and_model(8'h48);
    send_and_model(8'h69);
    base = log_addr.size();
    w0 = wr_cnt;
    send_byte(8'h0C, bc);
    model_apply(8'h0C);
    check("clr_writes", 32'(wr_cnt - w0), 32'(300));
    check("clr_busy_cycles", 32'(bc >= 1200), 32'(1));
    bad = 0;
    for (int i = 0; i < 300 && base + i < log_addr.size(); i++)
      if (log_data[base+i] != 32'h2020_2020 || log_strb[base+i] != 4'hF ||
          log_addr[base+i] != VRAM_BASE + 32'(4*i)) bad++;
    check("clr_contents", 32'(bad), 32'(0));
    check("clr_col", 32'(cursor_col), 32'(0));
    check("clr_row", 32'(cursor_row), 32'(0));
    check("clr_ch_ready", 32'(ch_ready), 32'(1));
    compare_vram("vram_cleared");

    // Backspace at col 5, at col 0, and an ignored control code
    for (int i = 0; i < 5; i++) send_and_model(8'h6B);
    send_and_model(8'h08);
    check_last_write("bs5", 32'h2000_0004, 4'h1, 32'h2020_2020);
    check("bs5_col", 32'(cursor_col), 32'(4));
    send_and_model(8'h0D);
    w0 = wr_cnt;
    send_and_model(8'h08);
    check("bs0_nwr", 32'(wr_cnt - w0), 32'(0));
    ch_valid = 1'b1;
    ch_data  = 8'h07;
    @(negedge clk);
    ch_valid = 1'b0;
    check("bel_ch_ready", 32'(ch_ready), 32'(1));
    check("bel_mem_valid", 32'(mem_valid), 32'(0));
    model_apply(8'h07);

    // Reset during scroll
    for (int i = 0; i < int'(ROWS) - 1; i++) send_and_model(8'h0A);
    ch_valid = 1'b1;
    ch_data  = 8'h0A;
    @(negedge clk);
    ch_valid = 1'b0;
    repeat (100) @(negedge clk);
    check("midscroll_busy", 32'(busy), 32'(1));
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_scroll_mem_valid", 32'(mem_valid), 32'(0));
    check("rst_scroll_col", 32'(cursor_col), 32'(0));
    check("rst_scroll_row", 32'(cursor_row), 32'(0));
    check("rst_scroll_ch_ready", 32'(ch_ready), 32'(1));
    @(negedge clk);
    reset_n = 1'b1;
    mc = 0;
    mr = 0;
    exp_wr = wr_cnt;
    exp_rd = rd_cnt;
    send_and_model(8'h5A);
    check_last_write("Z", 32'h2000_0000, 4'h1, 32'h5A5A_5A5A);
    send_and_model(8'h0C);
    compare_vram("vram_resync");

    // Random byte stream against the model
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 66)      b = 8'($urandom_range(32, 126));
      else if (r < 78) b = 8'h0A;
      else if (r < 85) b = 8'h0D;
      else if (r < 93) b = 8'h08;
      else if (r < 94) b = 8'h0C;
      else if (r < 97) b = 8'($urandom_range(127, 255));
      else             b = 8'h1B;
      send_and_model(b);
      if (i % 50 == 49) compare_vram($sformatf("vram_rand_%0d", i));
    end
    compare_vram("vram_rand_end");

    check("bus_protocol", 32'(prot_err), 32'(0));
    check("slave_address", 32'(slave_err), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
